grace_period_mc: RTL and testbench
==================================

Name: grace_period_mc

Overview:
Multi-channel, parametrised grace-period timer. It is the successor of the fixed 64-cycle single-channel grace counter used around link and PHY bring-up logic. Each channel holds its grace output high for a programmable number of prescaled ticks after a start pulse. It adds retrigger, abort, global hold, an expiry pulse and optional grace-at-reset.

Parameters:
NUM_CH, 4, number of independent channels (1..32)
CNT_W, 7, width of length/remaining counter; max length 2^CNT_W-1
DEFAULT_LEN, 64, length loaded at reset when GRACE_AT_RESET=1 (1..2^CNT_W-1)
PRESCALE, 1, clk cycles per tick (1..65536); 1 = tick every cycle
RETRIGGER, 1, 1 = start during grace reloads; 0 = start during grace ignored
GRACE_AT_RESET, 1, 1 = every channel is in grace out of reset; 0 = idle out of reset

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
len  in  CNT_W  grace length in ticks, shared by all channels, sampled on start
start  in  NUM_CH  per-channel start pulse
abort  in  NUM_CH  per-channel cancel
hold  in  1  global pause of all channel decrements
grace  out  NUM_CH  per-channel grace level
expire  out  NUM_CH  one-cycle pulse on natural end of grace
any_grace  out  1  OR of grace

Behaviour:
- Reset (rst_n=0, async): prescaler=0, expire=0.
  - GRACE_AT_RESET=1: every channel is in GRACE with rem=DEFAULT_LEN and grace=1, including while reset is held.
  - GRACE_AT_RESET=0: every channel is IDLE with rem=0 and grace=0.
- Reset asserted mid-operation immediately discards all state and returns to the reset values above. No expire pulse is produced.
- Prescaler: free-running 0..PRESCALE-1, unaffected by hold and start. tick=1 in the cycle the count equals PRESCALE-1; with PRESCALE=1, tick is constant 1.
- Per-channel FSM has two states, IDLE and GRACE, with grace=(state==GRACE), registered.
- IDLE:
  - start=1, abort=0, len!=0 -> GRACE, rem<=len.
  - start with len==0 is ignored: no grace, no expire.
- GRACE, evaluated in priority order:
  1. abort=1 -> IDLE next cycle, no expire. Abort beats start in the same cycle.
  2. start=1 and RETRIGGER=1 and len!=0 -> rem<=len, grace stays 1, no expire. Retrigger wins over a final tick in the same cycle.
  3. tick=1 and hold=0 and rem==1 -> IDLE, expire=1 in the next cycle only.
  4. tick=1 and hold=0 -> rem<=rem-1.
  5. Otherwise rem holds. A start with RETRIGGER=0 is ignored, including on the final-tick cycle.
- Latency with PRESCALE=1, hold=0 and start at cycle t:
  - grace=1 in cycles t+1..t+len, i.e. exactly len cycles.
  - In cycle t+len+1, grace=0 and expire=1.
- With PRESCALE=P, grace duration is between (len-1)*P+1 and len*P cycles, depending on prescaler phase.
- hold=1 freezes rem in all GRACE channels; grace stays 1 and no expire fires. Loads, retriggers and aborts still act during hold.
- The counter never wraps: rem never decrements below 1 while in GRACE and is not updated in IDLE.
- expire and grace are never 1 together for a channel. expire never fires after abort or reset.
- any_grace is a combinational OR of the registered grace bits.
- Channels are fully independent except for the shared len, hold and prescaler.

Test Plan:
- Defaults, release rst_n, no stimulus -> grace=4'hF for 64 cycles; then grace=0 and expire=4'hF for exactly 1 cycle; any_grace falls with grace.
- GRACE_AT_RESET=0, len=5, start[2] at cycle t -> grace[2]=1 in cycles t+1..t+5; expire[2]=1 at t+6 only; other channels stay 0.
- len=10, start[0] at t, second start[0] at t+6, RETRIGGER=1 -> grace[0] high through t+16, one expire at t+17. Same with RETRIGGER=0 -> expire at t+11.
- len=8, start[1] at t, abort[1] at t+3 -> grace[1]=0 from t+4, no expire. start+abort on the same cycle from IDLE -> stays IDLE.
- len=4, start[3] at t, hold=1 for cycles t+2..t+11 -> grace[3] high t+1..t+14, expire at t+15. rst_n pulsed low mid-grace -> outputs at reset values immediately, no expire.
- PRESCALE=4, len=3, start aligned so the first tick falls at t+1 -> grace high 9 cycles. len=0 start -> no grace, no expire.

Source files
------------

// File: rtl/grace_period_mc.sv
// -----------------------------------------------------------------------------
// grace_period_mc
//
// Multi-channel grace-period timer. Each channel raises its grace output for a
// programmable number of prescaled ticks after a start pulse. A shared
// free-running prescaler paces the countdown of every channel. Channels can be
// retriggered (parameter), aborted, and globally frozen with hold. A one-cycle
// expire pulse marks the natural end of a grace period. With GRACE_AT_RESET=1,
// every channel comes out of reset already in grace with DEFAULT_LEN ticks.
//
// Ports:
//   clk         : single clock
//   rst_n       : asynchronous active-low reset
//   len_i       : grace length in ticks, shared by all channels, sampled on start
//   start_i     : per-channel start pulse
//   abort_i     : per-channel cancel (no expire pulse)
//   hold_i      : global pause of all channel decrements
//   grace_o     : per-channel grace level (registered)
//   expire_o    : per-channel one-cycle pulse on natural end of grace (registered)
//   any_grace_o : OR of grace_o
// -----------------------------------------------------------------------------
module grace_period_mc #(
   parameter int NUM_CH         = 4,
   parameter int CNT_W          = 7,
   parameter int DEFAULT_LEN    = 64,
   parameter int PRESCALE       = 1,
   parameter bit RETRIGGER      = 1'b1,
   parameter bit GRACE_AT_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CNT_W-1:0]  len_i,
   input  logic [NUM_CH-1:0] start_i,
   input  logic [NUM_CH-1:0] abort_i,
   input  logic              hold_i,
   output logic [NUM_CH-1:0] grace_o,
   output logic [NUM_CH-1:0] expire_o,
   output logic              any_grace_o
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRACE = 1'b1
   } state_e;

   // A 1-bit prescaler with PRESCALE=1 stays at 0, which equals PS_LAST, so
   // tick is constantly high without a special case.
   localparam int              PS_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST   = PS_W'(PRESCALE - 1);
   localparam logic [PS_W-1:0] PS_ZERO   = {PS_W{1'b0}};
   localparam logic [PS_W-1:0] PS_ONE    = PS_W'(1);
   localparam logic [CNT_W-1:0] REM_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] REM_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] RST_REM  = GRACE_AT_RESET ? CNT_W'(DEFAULT_LEN) : REM_ZERO;
   localparam state_e           RST_STATE = GRACE_AT_RESET ? ST_GRACE : ST_IDLE;

   // Prescaler
   logic [PS_W-1:0]   ps_q;
   logic [PS_W-1:0]   ps_d;
   logic              tick_s;

   // Shared qualifiers
   logic              len_nz_s;
   logic              dec_s;

   // Per-channel state
   state_e            state_q [NUM_CH];
   state_e            state_d [NUM_CH];
   logic [CNT_W-1:0]  rem_q   [NUM_CH];
   logic [CNT_W-1:0]  rem_d   [NUM_CH];
   logic [NUM_CH-1:0] grace_q;
   logic [NUM_CH-1:0] grace_d;
   logic [NUM_CH-1:0] expire_q;
   logic [NUM_CH-1:0] expire_d;

   // Free-running prescaler: wraps after PRESCALE-1, unaffected by hold and start.
   always_comb begin
      tick_s = (ps_q == PS_LAST);
      if (tick_s) begin
         ps_d = PS_ZERO;
      end else begin
         ps_d = ps_q + PS_ONE;
      end
   end

   // Qualifiers shared by every channel.
   always_comb begin
      len_nz_s = (len_i != REM_ZERO);
      dec_s    = tick_s & ~hold_i;
   end

   // Per-channel next-state logic; priority in GRACE is abort, retrigger,
   // final tick, ordinary decrement, hold.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         state_d[i]  = state_q[i];
         rem_d[i]    = rem_q[i];
         expire_d[i] = 1'b0;
         case (state_q[i])
            ST_IDLE: begin
               // A zero-length start is dropped so the channel cannot enter
               // grace with rem=0 and underflow.
               if (start_i[i] && !abort_i[i] && len_nz_s) begin
                  state_d[i] = ST_GRACE;
                  rem_d[i]   = len_i;
               end else begin
                  state_d[i] = ST_IDLE;
               end
            end
            ST_GRACE: begin
               if (abort_i[i]) begin
                  state_d[i] = ST_IDLE;
               end else if (start_i[i] && RETRIGGER && len_nz_s) begin
                  rem_d[i] = len_i;
               end else if (dec_s && (rem_q[i] == REM_ONE)) begin
                  // rem stays at 1 in IDLE; it is only meaningful in GRACE.
                  state_d[i]  = ST_IDLE;
                  expire_d[i] = 1'b1;
               end else if (dec_s) begin
                  rem_d[i] = rem_q[i] - REM_ONE;
               end else begin
                  rem_d[i] = rem_q[i];
               end
            end
            default: begin
               state_d[i] = ST_IDLE;
               rem_d[i]   = REM_ZERO;
            end
         endcase
         grace_d[i] = (state_d[i] == ST_GRACE);
      end
   end

   // Registers: prescaler, channel FSMs and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ps_q     <= PS_ZERO;
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= RST_STATE;
            rem_q[i]   <= RST_REM;
         end
         grace_q  <= {NUM_CH{GRACE_AT_RESET}};
         expire_q <= {NUM_CH{1'b0}};
      end else begin
         ps_q     <= ps_d;
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= state_d[i];
            rem_q[i]   <= rem_d[i];
         end
         grace_q  <= grace_d;
         expire_q <= expire_d;
      end
   end

   // Output drive.
   always_comb begin
      grace_o     = grace_q;
      expire_o    = expire_q;
      any_grace_o = |grace_q;
   end

endmodule

// File: tb/tb_grace_period_mc.sv
// -----------------------------------------------------------------------------
// tb_grace_period_mc
//
// Three instances share one stimulus stream:
//   u_def : defaults (grace at reset, retrigger, PRESCALE=1)
//   u_nr  : idle at reset, no retrigger, PRESCALE=1
//   u_ps  : idle at reset, retrigger, PRESCALE=4
// Each step drives inputs for one cycle, pushes the expected outputs of the
// following cycle to a scoreboard and pops/compares them at the next negedge.
// -----------------------------------------------------------------------------
module tb_grace_period_mc;

   localparam int CW = 7;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [CW-1:0] len;
   logic [3:0]    start;
   logic [3:0]    abort;
   logic          hold;

   logic [3:0] g_def, e_def, g_nr, e_nr, g_ps, e_ps;
   logic       a_def, a_nr, a_ps;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      string      tag;
      logic [2:0] chk;
      logic [3:0] g0, e0, g1, e1, g2, e2;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   grace_period_mc #(.NUM_CH(4), .CNT_W(CW), .DEFAULT_LEN(64), .PRESCALE(1),
                     .RETRIGGER(1'b1), .GRACE_AT_RESET(1'b1)) u_def (
      .clk(clk), .rst_n(rst_n), .len_i(len), .start_i(start), .abort_i(abort),
      .hold_i(hold), .grace_o(g_def), .expire_o(e_def), .any_grace_o(a_def));

   grace_period_mc #(.NUM_CH(4), .CNT_W(CW), .DEFAULT_LEN(64), .PRESCALE(1),
                     .RETRIGGER(1'b0), .GRACE_AT_RESET(1'b0)) u_nr (
      .clk(clk), .rst_n(rst_n), .len_i(len), .start_i(start), .abort_i(abort),
      .hold_i(hold), .grace_o(g_nr), .expire_o(e_nr), .any_grace_o(a_nr));

   grace_period_mc #(.NUM_CH(4), .CNT_W(CW), .DEFAULT_LEN(64), .PRESCALE(4),
                     .RETRIGGER(1'b1), .GRACE_AT_RESET(1'b0)) u_ps (
      .clk(clk), .rst_n(rst_n), .len_i(len), .start_i(start), .abort_i(abort),
      .hold_i(hold), .grace_o(g_ps), .expire_o(e_ps), .any_grace_o(a_ps));

   function automatic logic [3:0] on_if(input logic [3:0] ch, input bit c);
      return c ? ch : 4'h0;
   endfunction

   task automatic cmp(input string tag, input string what, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s %s observed %h expected %h", tag, what, obs, exp);
      end
   endtask

   task automatic cmp_inst(input string tag, input int sel, input logic [3:0] eg, input logic [3:0] ee);
      logic [3:0] og, oe;
      logic       oa;
      case (sel)
         0:       begin og = g_def; oe = e_def; oa = a_def; end
         1:       begin og = g_nr;  oe = e_nr;  oa = a_nr;  end
         default: begin og = g_ps;  oe = e_ps;  oa = a_ps;  end
      endcase
      cmp(tag, $sformatf("inst%0d_grace", sel), og, eg);
      cmp(tag, $sformatf("inst%0d_expire", sel), oe, ee);
      cmp(tag, $sformatf("inst%0d_any", sel), {3'b000, oa}, {3'b000, |eg});
   endtask

   // Drive one cycle of inputs, queue expectations for the next cycle, check.
   task automatic step(input string tag, input logic [3:0] st, input logic [3:0] ab, input logic hd,
                       input logic [2:0] chk,
                       input logic [3:0] g0, input logic [3:0] e0,
                       input logic [3:0] g1, input logic [3:0] e1,
                       input logic [3:0] g2, input logic [3:0] e2);
      exp_t x;
      start = st;
      abort = ab;
      hold  = hd;
      x.tag = tag; x.chk = chk;
      x.g0 = g0; x.e0 = e0; x.g1 = g1; x.e1 = e1; x.g2 = g2; x.e2 = e2;
      sb.push_back(x);
      @(negedge clk);
      cyc++;
      x = sb.pop_front();
      if (x.chk[0]) cmp_inst(x.tag, 0, x.g0, x.e0);
      if (x.chk[1]) cmp_inst(x.tag, 1, x.g1, x.e1);
      if (x.chk[2]) cmp_inst(x.tag, 2, x.g2, x.e2);
   endtask

   task automatic gap(input int n);
      for (int k = 0; k < n; k++)
         step("gap", 4'h0, 4'h0, 1'b0, 3'b000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
   endtask

   initial begin
      int o;
      rst_n = 1'b0;
      len   = 7'd0;
      start = 4'h0;
      abort = 4'h0;
      hold  = 1'b0;
      repeat (3) @(negedge clk);
      cmp_inst("reset", 0, 4'hF, 4'h0);
      cmp_inst("reset", 1, 4'h0, 4'h0);
      cmp_inst("reset", 2, 4'h0, 4'h0);

      // Default instance: 64 cycles of grace after release, then one expire.
      rst_n = 1'b1;
      cyc   = 0;
      cmp_inst("release", 0, 4'hF, 4'h0);
      for (int j = 1; j <= 66; j++)
         step("t1_default", 4'h0, 4'h0, 1'b0, 3'b111,
              on_if(4'hF, j <= 63), on_if(4'hF, j == 64), 4'h0, 4'h0, 4'h0, 4'h0);

      // len=5 on channel 2.
      len = 7'd5;
      for (int i = 0; i <= 6; i++) begin
         o = i + 1;
         step("t2_len5", (i == 0) ? 4'h4 : 4'h0, 4'h0, 1'b0, 3'b011,
              on_if(4'h4, o <= 5), on_if(4'h4, o == 6),
              on_if(4'h4, o <= 5), on_if(4'h4, o == 6), 4'h0, 4'h0);
      end

      // len=10, second start at t+6: retrigger vs ignore.
      len = 7'd10;
      for (int i = 0; i <= 18; i++) begin
         o = i + 1;
         step("t3_retrig", (i == 0 || i == 6) ? 4'h1 : 4'h0, 4'h0, 1'b0, 3'b011,
              on_if(4'h1, o <= 16), on_if(4'h1, o == 17),
              on_if(4'h1, o <= 10), on_if(4'h1, o == 11), 4'h0, 4'h0);
      end

      // len=3, second start on the final-tick cycle.
      len = 7'd3;
      for (int i = 0; i <= 8; i++) begin
         o = i + 1;
         step("t3b_final_tick", (i == 0 || i == 3) ? 4'h1 : 4'h0, 4'h0, 1'b0, 3'b011,
              on_if(4'h1, o <= 6), on_if(4'h1, o == 7),
              on_if(4'h1, o <= 3), on_if(4'h1, o == 4), 4'h0, 4'h0);
      end

      // len=8 on channel 1, abort at t+3: no expire ever.
      len = 7'd8;
      for (int i = 0; i <= 11; i++) begin
         o = i + 1;
         step("t4_abort", (i == 0) ? 4'h2 : 4'h0, (i == 3) ? 4'h2 : 4'h0, 1'b0, 3'b011,
              on_if(4'h2, o <= 3), 4'h0, on_if(4'h2, o <= 3), 4'h0, 4'h0, 4'h0);
      end
      for (int i = 0; i <= 2; i++)
         step("t4_start_abort", (i == 0) ? 4'h2 : 4'h0, (i == 0) ? 4'h2 : 4'h0, 1'b0, 3'b011,
              4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

      // len=4 on channel 3, hold over t+2..t+11.
      len = 7'd4;
      for (int i = 0; i <= 16; i++) begin
         o = i + 1;
         step("t5_hold", (i == 0) ? 4'h8 : 4'h0, 4'h0, (i >= 2 && i <= 11), 3'b011,
              on_if(4'h8, o <= 14), on_if(4'h8, o == 15),
              on_if(4'h8, o <= 14), on_if(4'h8, o == 15), 4'h0, 4'h0);
      end

      gap(50);

      // Zero-length start on all channels is ignored everywhere.
      len = 7'd0;
      for (int i = 0; i <= 3; i++)
         step("t6_len0", (i == 0) ? 4'hF : 4'h0, 4'h0, 1'b0, 3'b111,
              4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

      // PRESCALE=4, len=3, start placed so the first tick falls at t+1.
      for (int k = 0; k < 4 && (cyc % 4) != 2; k++) gap(1);
      len = 7'd3;
      for (int i = 0; i <= 11; i++) begin
         o = i + 1;
         step("t7_prescale", (i == 0) ? 4'h1 : 4'h0, 4'h0, 1'b0, 3'b111,
              on_if(4'h1, o <= 3), on_if(4'h1, o == 4),
              on_if(4'h1, o <= 3), on_if(4'h1, o == 4),
              on_if(4'h1, o <= 9), on_if(4'h1, o == 10));
      end

      // Reset in the middle of grace: immediate reset values, no expire after.
      len = 7'd20;
      step("t8_load", 4'hF, 4'h0, 1'b0, 3'b000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      gap(3);
      rst_n = 1'b0;
      #1;
      cmp_inst("t8_async_rst", 0, 4'hF, 4'h0);
      cmp_inst("t8_async_rst", 1, 4'h0, 4'h0);
      cmp_inst("t8_async_rst", 2, 4'h0, 4'h0);
      @(negedge clk);
      cmp_inst("t8_rst_held", 0, 4'hF, 4'h0);
      cmp_inst("t8_rst_held", 1, 4'h0, 4'h0);
      cmp_inst("t8_rst_held", 2, 4'h0, 4'h0);
      rst_n = 1'b1;
      cyc   = 0;
      for (int i = 0; i < 3; i++)
         step("t8_after_rst", 4'h0, 4'h0, 1'b0, 3'b111, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
